// File: rtl/vebpf_dump_trigger_ctrl_if.sv
// Handshake bundle between the test sequencer and the dump trigger controller.
//   master: drives start/test_num/dump_en/cpu_halt, observes results.
//   slave : the controller; consumes the requests, drives filename, trigger and run status.
interface vebpf_dump_trigger_ctrl_if #(
  parameter int unsigned WIDTH_OF_STRING = 8192
);
  localparam int unsigned NUM_W = 8;
  localparam int unsigned CNT_W = 32;

  logic                       start;
  logic [NUM_W-1:0]           test_num;
  logic                       dump_en;
  logic                       cpu_halt;
  logic [WIDTH_OF_STRING-1:0] dump_name;
  logic                       dump_trig;
  logic                       busy;
  logic                       done;
  logic                       timeout;
  logic [CNT_W-1:0]           cycle_count;

  modport master (
    output start, test_num, dump_en, cpu_halt,
    input  dump_name, dump_trig, busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, test_num, dump_en, cpu_halt,
    output dump_name, dump_trig, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/vebpf_dump_trigger_ctrl.sv
// Sequencer for the waveform-dump helper. On an accepted start it renders
// "test_<N>.fst" as packed ASCII (last char in bits [7:0]), pulses dump_trig
// for one cycle, then times the CPU run until cpu_halt or MAX_CYCLES and
// pulses done.
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   bus       - slave side: start/test_num/dump_en/cpu_halt in;
//               dump_name/dump_trig/busy/done/timeout/cycle_count out (all registered)
module vebpf_dump_trigger_ctrl #(
  parameter int unsigned WIDTH_OF_STRING = 8192,
  parameter int unsigned MAX_CYCLES      = 65535,
  parameter int unsigned VEBPF_SIM       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  vebpf_dump_trigger_ctrl_if.slave  bus
);
  localparam int unsigned NUM_W  = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned NAME_W = 96;
  localparam int unsigned DIG_W  = 24;
  localparam logic        TRIG_EN = (VEBPF_SIM != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUILD = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                     state;
  logic [NUM_W-1:0]           val;
  logic                       en_q;
  logic [DIG_W-9:0]           digits;   // previously produced digits, most recent in the top byte
  logic [1:0]                 ndig;
  logic [WIDTH_OF_STRING-1:0] dump_name;
  logic                       dump_trig;
  logic                       busy;
  logic                       done;
  logic                       timeout;
  logic [CNT_W-1:0]           cycle_count;

  logic [NUM_W-1:0]  val_next_c;
  logic [7:0]        digit_c;
  logic [DIG_W-1:0]  digits_next_c;
  logic [1:0]        ndig_next_c;
  logic [NAME_W-1:0] name_c;
  logic [CNT_W-1:0]  count_inc_c;
  logic              limit_c;

  // Digit extraction and filename assembly. Digits come out LSD first, so each
  // new one is prepended, leaving the most significant digit leftmost.
  always_comb begin
    val_next_c    = val / 8'd10;
    digit_c       = 8'h30 + (val % 8'd10);
    digits_next_c = {digit_c, digits};
    ndig_next_c   = ndig + 2'd1;
    case (ndig_next_c)
      2'd1:    name_c = {16'h0000, "test_", digits_next_c[23:16], ".fst"};
      2'd2:    name_c = {8'h00, "test_", digits_next_c[23:8], ".fst"};
      default: name_c = {"test_", digits_next_c, ".fst"};
    endcase
    count_inc_c = cycle_count + 32'd1;
    limit_c     = (count_inc_c == CNT_W'(MAX_CYCLES));
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      val         <= '0;
      en_q        <= 1'b0;
      digits      <= '0;
      ndig        <= '0;
      dump_name   <= '0;
      dump_trig   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            val         <= bus.test_num;
            en_q        <= bus.dump_en;
            digits      <= '0;
            ndig        <= '0;
            dump_name   <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            busy        <= 1'b1;
            state       <= BUILD;
          end
        end
        BUILD: begin
          val    <= val_next_c;
          digits <= digits_next_c[DIG_W-1:8];
          ndig   <= ndig_next_c;
          // Final digit: publish the name together with the move to ARM.
          if (val_next_c == '0) begin
            dump_name <= WIDTH_OF_STRING'(name_c);
            dump_trig <= TRIG_EN & en_q;
            state     <= ARM;
          end
        end
        ARM: begin
          dump_trig <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          cycle_count <= count_inc_c;
          // Halt takes priority over the limit when both land together.
          if (bus.cpu_halt) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (limit_c) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dump_name   = dump_name;
  assign bus.dump_trig   = dump_trig;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.timeout     = timeout;
  assign bus.cycle_count = cycle_count;

endmodule
